// File: rtl/xor_vector_checker.sv
// On-board self-test sequencer for a 2-input XOR stage: sweeps {x,y} through
// 00..11, samples z after a settle window and tallies mismatches.
module xor_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_fail
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(NUM_PASSES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_n;
  logic [1:0]       vec_idx, vec_n;
  logic [PW-1:0]    pass_cnt, pass_n;
  logic [SW-1:0]    settle_cnt, settle_n;
  logic [CNT_W-1:0] err_n;
  logic [1:0]       ff_n;
  logic [1:0]       xy_q, xy_n;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_idx    <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      first_fail <= '0;
      xy_q       <= '0;
    end else begin
      state      <= state_n;
      vec_idx    <= vec_n;
      pass_cnt   <= pass_n;
      settle_cnt <= settle_n;
      err_count  <= err_n;
      first_fail <= ff_n;
      xy_q       <= xy_n;
    end
  end

  // x/y come straight from xy_q so z is compared against the exact vector driven
  assign mismatch = z != (xy_q[1] ^ xy_q[0]);

  always_comb begin
    state_n  = state;
    vec_n    = vec_idx;
    pass_n   = pass_cnt;
    settle_n = settle_cnt;
    err_n    = err_count;
    ff_n     = first_fail;
    xy_n     = xy_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = SETTLE;
          vec_n    = '0;
          pass_n   = '0;
          settle_n = '0;
          err_n    = '0;
          ff_n     = '0;
          xy_n     = '0;
        end
      end
      SETTLE: begin
        settle_n = settle_cnt + 1'b1;
        if (settle_cnt == SETTLE_LAST) state_n = CHECK;
      end
      CHECK: begin
        settle_n = '0;
        if (mismatch) begin
          if (err_count != '1) err_n = err_count + CNT_W'(1);
          if (err_count == '0) ff_n = vec_idx;
        end
        if (vec_idx == 2'd3) begin
          xy_n  = '0;
          vec_n = '0;
          if (pass_cnt == PASS_LAST) begin
            state_n = DONE;
          end else begin
            pass_n  = pass_cnt + 1'b1;
            state_n = SETTLE;
          end
        end else begin
          vec_n   = vec_idx + 2'd1;
          xy_n    = vec_idx + 2'd1;
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign x    = xy_q[1];
  assign y    = xy_q[0];
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);
endmodule

// File: tb/tb_xor_vector_checker.sv
// Directed bench: default checker against a modelled XOR stage (good, stuck-0,
// OR) plus a saturating CNT_W=2 / NUM_PASSES=3 instance.
module tb_xor_vector_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start_s = 1'b0;
  logic [1:0] zmode = 2'd0;
  logic z, x, y, busy, done, pass;
  logic [3:0] err_count;
  logic [1:0] first_fail;
  logic xs, ys, busy_s, done_s, pass_s;
  logic [1:0] err_s, ff_s;
  int applied = 0, miscompares = 0;

  always #5 clk = ~clk;

  // 0: correct XOR, 1: stuck at 0, 2: OR instead of XOR
  assign z = (zmode == 2'd0) ? (x ^ y) : (zmode == 2'd1) ? 1'b0 : (x | y);

  xor_vector_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z(z), .x(x), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail));

  xor_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .z(1'b0), .x(xs), .y(ys),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .first_fail(ff_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 12-cycle run on u_dut; edge 0 is the first posedge with start high.
  task automatic sweep(input bit launch, input bit keep, input logic [3:0] exp_err,
                       input logic [1:0] exp_ff, input bit chk_ff);
    logic [1:0] seq [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                             2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    if (launch) begin
      @(negedge clk) start = 1'b1;
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0 && !keep) start = 1'b0;
      chk($sformatf("busy@%0d", k), busy, 1'b1);
      chk($sformatf("xy@%0d", k), {x, y}, seq[k]);
      if (k == 0) begin
        chk("err_clear", err_count, 4'd0);
        chk("done_low", done, 1'b0);
      end
    end
    @(posedge clk); #1;
    chk("done@12", done, 1'b1);
    chk("busy@12", busy, 1'b0);
    chk("xy@12", {x, y}, 2'd0);
    chk("err", err_count, exp_err);
    chk("pass", pass, exp_err == 4'd0);
    if (chk_ff) chk("first_fail", first_fail, exp_ff);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_xy", {x, y}, 2'd0);
    chk("rst_err", err_count, 4'd0);
    chk("rst_ff", first_fail, 2'd0);
    @(negedge clk) rst_n = 1'b1;

    zmode = 2'd0; sweep(1, 0, 4'd0, 2'd0, 0);
    // done is held in DONE until a new start
    repeat (3) @(posedge clk);
    #1 chk("done_hold", done, 1'b1);
    chk("pass_hold", pass, 1'b1);

    zmode = 2'd1; sweep(1, 0, 4'd2, 2'd1, 1);
    zmode = 2'd2; sweep(1, 0, 4'd1, 2'd3, 1);

    // async reset mid-run
    zmode = 2'd0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_xy", {x, y}, 2'd1);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_busy", busy, 1'b0);
    chk("async_xy", {x, y}, 2'd0);
    chk("async_done", done, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    sweep(1, 0, 4'd0, 2'd0, 0);

    // start held through both runs: DONE lasts one cycle, second run identical
    zmode = 2'd1;
    sweep(1, 1, 4'd2, 2'd1, 1);
    sweep(0, 1, 4'd2, 2'd1, 1);
    @(negedge clk) start = 1'b0;

    // saturating instance: 6 mismatches into a 2-bit counter
    @(negedge clk) start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    chk("sat_busy0", busy_s, 1'b1);
    repeat (35) @(posedge clk);
    #1 chk("sat_busy35", busy_s, 1'b1);
    chk("sat_done35", done_s, 1'b0);
    @(posedge clk); #1;
    chk("sat_done36", done_s, 1'b1);
    chk("sat_err", err_s, 2'd3);
    chk("sat_ff", ff_s, 2'd1);
    chk("sat_pass", pass_s, 1'b0);
    chk("sat_xy", {xs, ys}, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
